hash_generator: RTL and testbench

Keystream source for the stream cipher. It answers single-cycle byte requests from `encryption_block` with a single-cycle `hash_byte_pulse` and a keystream byte. The byte comes from a 16-bit Galois LFSR that is stepped eight times per byte. The block also accepts a 16-bit key load from the data router, and exposes its state so requesters know when a request may be issued.

---
 rtl/types_pkg.sv | 13 +
 rtl/hash_generator.sv | 87 ++++++++
 tb/tb_hash_generator.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types and constants for the cipher datapath
package types_pkg;

  typedef enum logic [1:0] {
    GROUND     = 2'd0,
    READY      = 2'd1,
    GENERATING = 2'd2
  } hash_generator_state_t;

  localparam logic [15:0] HASH_SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] HASH_TAPS_DEFAULT = 16'hB400;

endpackage

// File: rtl/hash_generator.sv
// rtl/hash_generator.sv - keystream byte source built on a 16-bit Galois LFSR
module hash_generator
  import types_pkg::*;
#(
  parameter logic [15:0] SEED = HASH_SEED_DEFAULT,
  parameter logic [15:0] TAPS = HASH_TAPS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [15:0]           key_in,
  input  logic                  key_load_pulse,
  input  logic                  request_byte_pulse,
  output logic [7:0]            hash_byte,
  output logic                  hash_byte_pulse,
  output hash_generator_state_t hash_generator_state_out
);

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? TAPS : 16'h0000);
  endfunction

  hash_generator_state_t state, state_nxt;
  logic [15:0]           lfsr, lfsr_nxt;
  logic [2:0]            cnt, cnt_nxt;
  logic [7:0]            shreg, shreg_nxt;
  logic                  byte_done;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= GROUND;
      lfsr  <= SEED;
      cnt   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Key load and request in the same cycle: the load wins the LFSR, the request still starts.
  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    byte_done = 1'b0;
    unique case (state)
      GROUND, READY: begin
        if (key_load_pulse) begin
          lfsr_nxt  = (key_in == 16'h0000) ? SEED : key_in;
          state_nxt = READY;
        end
        if (request_byte_pulse) begin
          state_nxt = GENERATING;
          cnt_nxt   = 3'd0;
        end
      end
      GENERATING: begin
        shreg_nxt[cnt] = lfsr[0];
        lfsr_nxt       = lfsr_step(lfsr);
        cnt_nxt        = cnt + 3'd1;
        if (cnt == 3'd7) begin
          byte_done = 1'b1;
          state_nxt = READY;
        end
      end
      default: state_nxt = GROUND;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hash_byte       <= 8'h00;
      hash_byte_pulse <= 1'b0;
    end else begin
      hash_byte_pulse <= byte_done;
      if (byte_done) begin
        hash_byte <= shreg_nxt;
      end
    end
  end

  assign hash_generator_state_out = state;

endmodule

// File: tb/tb_hash_generator.sv
// tb/tb_hash_generator.sv - scoreboard bench for hash_generator
module tb_hash_generator;
  import types_pkg::*;

  logic                  clk;
  logic                  nrst;
  logic [15:0]           key_in;
  logic                  key_load_pulse;
  logic                  request_byte_pulse;
  logic [7:0]            hash_byte;
  logic                  hash_byte_pulse;
  hash_generator_state_t state_out;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         pulse_count = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] exp_q[$];

  hash_generator dut (
    .clk                      (clk),
    .nrst                     (nrst),
    .key_in                   (key_in),
    .key_load_pulse           (key_load_pulse),
    .request_byte_pulse       (request_byte_pulse),
    .hash_byte                (hash_byte),
    .hash_byte_pulse          (hash_byte_pulse),
    .hash_generator_state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  always @(negedge clk) begin
    if (hash_byte_pulse === 1'b1) begin
      pulse_count++;
      if (prev_pulse) check("pulse_consecutive", 32'd1, 32'd0);
      if (exp_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
      else check("hash_byte", 32'(hash_byte), 32'(exp_q.pop_front()));
    end
    prev_pulse = hash_byte_pulse;
  end

  // Called right after a negedge; returns at the negedge after the request edge.
  task automatic issue_request(input logic with_key, input logic [15:0] key,
                               input logic [7:0] exp_byte, input string tag);
    request_byte_pulse = 1'b1;
    key_load_pulse     = with_key;
    key_in             = key;
    @(negedge clk);
    request_byte_pulse = 1'b0;
    key_load_pulse     = 1'b0;
    exp_q.push_back(exp_byte);
    check({tag, "_state_gen"}, 32'(state_out), 32'(GENERATING));
  endtask

  task automatic await_pulse(input int exp_lat, input logic [7:0] exp_byte, input string tag);
    int lat  = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (hash_byte_pulse === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, "_pulse_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_state_ready"}, 32'(state_out), 32'(READY));
      @(negedge clk);
      check({tag, "_pulse_width"}, 32'(hash_byte_pulse), 32'd0);
      check({tag, "_byte_held"}, 32'(hash_byte), 32'(exp_byte));
    end
  endtask

  task automatic load_key(input logic [15:0] key, input string tag);
    key_load_pulse = 1'b1;
    key_in         = key;
    @(negedge clk);
    key_load_pulse = 1'b0;
    check({tag, "_state_ready"}, 32'(state_out), 32'(READY));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base_pulses;
    nrst               = 1'b0;
    key_in             = 16'h0000;
    key_load_pulse     = 1'b0;
    request_byte_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_out), 32'(GROUND));
    check("rst_hash_byte", 32'(hash_byte), 32'h00);
    check("rst_pulse", 32'(hash_byte_pulse), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    issue_request(1'b0, 16'h0000, 8'hE1, "seed1");
    await_pulse(8, 8'hE1, "seed1");
    issue_request(1'b0, 16'h0000, 8'hC4, "seed2");
    await_pulse(8, 8'hC4, "seed2");

    load_key(16'h1234, "key1234");
    issue_request(1'b0, 16'h0000, 8'h34, "key1234");
    await_pulse(8, 8'h34, "key1234");

    load_key(16'h0000, "key0");
    issue_request(1'b0, 16'h0000, 8'hE1, "key0");
    await_pulse(8, 8'hE1, "key0");

    do_reset();
    base_pulses = pulse_count;
    issue_request(1'b0, 16'h0000, 8'hE1, "interf");
    repeat (2) @(negedge clk);
    request_byte_pulse = 1'b1;
    key_load_pulse     = 1'b1;
    key_in             = 16'h5555;
    @(negedge clk);
    request_byte_pulse = 1'b0;
    key_load_pulse     = 1'b0;
    await_pulse(5, 8'hE1, "interf");
    repeat (5) @(negedge clk);
    check("interf_pulse_count", 32'(pulse_count - base_pulses), 32'd1);
    issue_request(1'b0, 16'h0000, 8'hC4, "interf_next");
    await_pulse(8, 8'hC4, "interf_next");

    issue_request(1'b1, 16'h00AB, 8'hAB, "same_cycle");
    await_pulse(8, 8'hAB, "same_cycle");

    base_pulses = pulse_count;
    request_byte_pulse = 1'b1;
    @(negedge clk);
    request_byte_pulse = 1'b0;
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("midrst_state", 32'(state_out), 32'(GROUND));
    check("midrst_hash_byte", 32'(hash_byte), 32'h00);
    check("midrst_pulse", 32'(hash_byte_pulse), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_no_pulse", 32'(pulse_count - base_pulses), 32'd0);
    issue_request(1'b0, 16'h0000, 8'hE1, "after_rst");
    await_pulse(8, 8'hE1, "after_rst");

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
